// File: rtl/wb_burst_master.sv
// -----------------------------------------------------------------------------
// wb_burst_master
//
// Wishbone B3 initiator for exercising a memory slave. It accepts one command
// at a time. Each command gives a start address, a beat count, a direction
// and a seed, and the block issues one incrementing linear burst:
//   write : every beat carries the pattern (beat byte address ^ seed)
//   read  : every returned beat is compared against that same pattern
// When the burst ends, a one-cycle response reports the mismatch count, the
// first mismatching address, and whether the burst was aborted by a timeout
// or by wb_err_i.
//
// Ports
//   sys_clk, RESETN        clock (rising edge), synchronous active-low reset
//   cmd_valid / cmd_ready  command handshake; ready only while idle
//   cmd_we                 1 = write burst, 0 = read-and-compare burst
//   cmd_addr               start byte address (bits [1:0] ignored)
//   cmd_len                beats minus one
//   cmd_seed               pattern seed
//   rsp_valid              one-cycle completion pulse
//   rsp_err_cnt            mismatching read beats
//   rsp_first_err_addr     byte address of the first mismatch (0 if none)
//   rsp_timeout            burst aborted because the slave stopped answering
//   rsp_bus_err            burst aborted by wb_err_i
//   busy                   a command is in progress
//   wb_*                   Wishbone B3 master signals
// -----------------------------------------------------------------------------
module wb_burst_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int BL      = 5,
    parameter int TIMEOUT = 256
) (
    input  logic          sys_clk,
    input  logic          RESETN,

    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [BL-1:0] cmd_len,
    input  logic [DW-1:0] cmd_seed,

    output logic          rsp_valid,
    output logic [BL:0]   rsp_err_cnt,
    output logic [AW-1:0] rsp_first_err_addr,
    output logic          rsp_timeout,
    output logic          rsp_bus_err,
    output logic          busy,

    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [3:0]    wb_sel_o,
    output logic [AW-1:0] wb_addr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);

    // The timeout counter only has to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t state, next_state;

    // Captured command and burst progress
    logic          we_r;
    logic [BL-1:0] len_r;
    logic [DW-1:0] seed_r;
    logic [AW-1:0] addr_r;
    logic [BL-1:0] beat_r;
    logic [TW-1:0] to_cnt;

    // Result registers; they hold until the next command is accepted
    logic [BL:0]   err_cnt;
    logic [AW-1:0] first_err_addr;
    logic          timeout_r;
    logic          bus_err_r;

    logic          last_beat;
    logic          to_expired;
    logic          rd_mismatch;

    // Byte-lane offset bits of the command address are not used
    logic          unused_addr_bits;
    assign unused_addr_bits = &{1'b0, cmd_addr[1:0]};

    // Pattern carried by the beat at byte address a
    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a,
                                              input logic [DW-1:0] s);
        return DW'(a) ^ s;
    endfunction

    assign last_beat   = (beat_r == len_r);
    assign to_expired  = (to_cnt == TW'(TIMEOUT - 1));
    assign rd_mismatch = (wb_dat_i != pattern(addr_r, seed_r));

    // ---------------- state register ----------------
    always_ff @(posedge sys_clk) begin
        if (!RESETN) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- next state and bus outputs ----------------
    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        rsp_valid  = 1'b0;
        wb_cyc_o   = 1'b0;
        wb_stb_o   = 1'b0;
        wb_we_o    = 1'b0;
        wb_sel_o   = 4'h0;
        wb_addr_o  = '0;
        wb_dat_o   = '0;
        wb_cti_o   = CTI_CLASSIC;
        wb_bte_o   = 2'b00;

        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    next_state = S_BURST;
                end
            end

            S_BURST: begin
                wb_cyc_o  = 1'b1;
                wb_stb_o  = 1'b1;
                wb_we_o   = we_r;
                wb_sel_o  = 4'hF;
                wb_addr_o = addr_r;
                wb_dat_o  = we_r ? pattern(addr_r, seed_r) : '0;
                if (len_r == '0) begin
                    wb_cti_o = CTI_CLASSIC;
                end else if (last_beat) begin
                    wb_cti_o = CTI_END;
                end else begin
                    wb_cti_o = CTI_INCR;
                end

                // err takes priority over a simultaneous ack
                if (wb_err_i) begin
                    next_state = S_RESP;
                end else if (wb_ack_i) begin
                    if (last_beat) begin
                        next_state = S_RESP;
                    end
                end else if (to_expired) begin
                    next_state = S_RESP;
                end
            end

            S_RESP: begin
                rsp_valid  = 1'b1;
                next_state = S_IDLE;
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // ---------------- command capture, beat tracking, results ----------------
    always_ff @(posedge sys_clk) begin
        if (!RESETN) begin
            we_r           <= 1'b0;
            len_r          <= '0;
            seed_r         <= '0;
            addr_r         <= '0;
            beat_r         <= '0;
            to_cnt         <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            timeout_r      <= 1'b0;
            bus_err_r      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        we_r           <= cmd_we;
                        len_r          <= cmd_len;
                        seed_r         <= cmd_seed;
                        addr_r         <= {cmd_addr[AW-1:2], 2'b00};
                        beat_r         <= '0;
                        to_cnt         <= '0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        timeout_r      <= 1'b0;
                        bus_err_r      <= 1'b0;
                    end
                end

                S_BURST: begin
                    if (wb_err_i) begin
                        bus_err_r <= 1'b1;
                    end else if (wb_ack_i) begin
                        to_cnt <= '0;
                        addr_r <= addr_r + AW'(4);
                        beat_r <= beat_r + BL'(1);
                        if (!we_r && rd_mismatch) begin
                            err_cnt <= err_cnt + (BL+1)'(1);
                            if (err_cnt == '0) begin
                                first_err_addr <= addr_r;
                            end
                        end
                    end else if (to_expired) begin
                        timeout_r <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign rsp_err_cnt        = err_cnt;
    assign rsp_first_err_addr = first_err_addr;
    assign rsp_timeout        = timeout_r;
    assign rsp_bus_err        = bus_err_r;

endmodule

// File: tb/tb_wb_burst_master.sv
// -----------------------------------------------------------------------------
// tb_wb_burst_master
//
// Directed bench for wb_burst_master. A transaction-level model follows each
// command (beats done, idle run since the last ack, expected results) and is
// compared with the DUT on every falling edge. A small slave with a memory
// answers the bursts with programmable wait states, corrupted data, errors or
// no answer at all. Hand-computed literals pin the model's key results.
// -----------------------------------------------------------------------------
module tb_wb_burst_master;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int BL      = 5;
    localparam int TIMEOUT = 16;

    logic          sys_clk = 1'b0;
    logic          RESETN  = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [BL-1:0] cmd_len = '0;
    logic [DW-1:0] cmd_seed = '0;
    logic          rsp_valid;
    logic [BL:0]   rsp_err_cnt;
    logic [AW-1:0] rsp_first_err_addr;
    logic          rsp_timeout;
    logic          rsp_bus_err;
    logic          busy;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [3:0]    wb_sel_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_dat_o;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;
    logic [DW-1:0] wb_dat_i = '0;
    logic          wb_ack_i = 1'b0;
    logic          wb_err_i = 1'b0;

    always #5 sys_clk = ~sys_clk;

    wb_burst_master #(.AW(AW), .DW(DW), .BL(BL), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk            (sys_clk),
        .RESETN             (RESETN),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_we             (cmd_we),
        .cmd_addr           (cmd_addr),
        .cmd_len            (cmd_len),
        .cmd_seed           (cmd_seed),
        .rsp_valid          (rsp_valid),
        .rsp_err_cnt        (rsp_err_cnt),
        .rsp_first_err_addr (rsp_first_err_addr),
        .rsp_timeout        (rsp_timeout),
        .rsp_bus_err        (rsp_bus_err),
        .busy               (busy),
        .wb_cyc_o           (wb_cyc_o),
        .wb_stb_o           (wb_stb_o),
        .wb_we_o            (wb_we_o),
        .wb_sel_o           (wb_sel_o),
        .wb_addr_o          (wb_addr_o),
        .wb_dat_o           (wb_dat_o),
        .wb_cti_o           (wb_cti_o),
        .wb_bte_o           (wb_bte_o),
        .wb_dat_i           (wb_dat_i),
        .wb_ack_i           (wb_ack_i),
        .wb_err_i           (wb_err_i)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    typedef enum {M_IDLE, M_BURST, M_RESP} mphase_t;
    mphase_t     m_phase = M_IDLE;
    bit          m_on = 1'b0;
    logic [31:0] m_base, m_seed;
    int          m_len, m_beats, m_run;
    bit          m_we;
    int          m_err = 0;
    logic [31:0] m_first = '0;
    bit          m_to = 1'b0, m_be = 1'b0;

    int          stb_cycles = 0;
    int          log_n = 0;
    logic [31:0] log_dat [0:31];
    logic [2:0]  log_cti [0:31];
    logic [31:0] mem [logic [31:0]];

    // Inputs as seen by the DUT at the last rising edge
    bit          s_resetn = 1'b0, s_cmd_valid = 1'b0, s_cmd_we = 1'b0;
    logic [31:0] s_cmd_addr, s_cmd_seed;
    int          s_cmd_len;
    // Bus state just before the last rising edge
    bit          p_stb = 1'b0, p_ack = 1'b0, p_err = 1'b0;
    logic [31:0] p_dat_i, p_dat_o;
    logic [2:0]  p_cti;

    // Slave configuration
    bit          rand_waits = 1'b0, never_ack = 1'b0, use_bad = 1'b0, new_beat = 1'b1;
    int          fixed_wait = 0, err_beat = -1, wait_left = 0;
    logic [31:0] bad_addr = '0;

    always @(posedge sys_clk) begin
        s_resetn    = RESETN;
        s_cmd_valid = cmd_valid;
        s_cmd_we    = cmd_we;
        s_cmd_addr  = cmd_addr;
        s_cmd_len   = int'(cmd_len);
        s_cmd_seed  = cmd_seed;
    end

    always @(negedge sys_clk) begin
        logic [31:0] ea;
        // What the last rising edge did
        if (!s_resetn) begin
            m_on = 1'b1; m_phase = M_IDLE;
            m_err = 0; m_first = '0; m_to = 1'b0; m_be = 1'b0;
            new_beat = 1'b1; wait_left = 0;
        end else if (m_on) begin
            case (m_phase)
                M_RESP: m_phase = M_IDLE;
                M_IDLE: if (s_cmd_valid) begin
                    m_we = s_cmd_we; m_len = s_cmd_len; m_seed = s_cmd_seed;
                    m_base = {s_cmd_addr[31:2], 2'b00};
                    m_beats = 0; m_run = 0;
                    m_err = 0; m_first = '0; m_to = 1'b0; m_be = 1'b0;
                    stb_cycles = 0; log_n = 0;
                    m_phase = M_BURST;
                end
                M_BURST: begin
                    ea = m_base + 32'(4 * m_beats);
                    if (p_err) begin
                        m_be = 1'b1; m_phase = M_RESP;
                    end else if (p_ack) begin
                        if (m_we) mem[ea] = p_dat_o;
                        else if (p_dat_i !== (ea ^ m_seed)) begin
                            if (m_err == 0) m_first = ea;
                            m_err++;
                        end
                        log_dat[log_n] = p_dat_o;
                        log_cti[log_n] = p_cti;
                        log_n++;
                        m_beats++; m_run = 0;
                        if (m_beats > m_len) m_phase = M_RESP;
                    end else begin
                        m_run++;
                        if (m_run == TIMEOUT) begin
                            m_to = 1'b1; m_phase = M_RESP;
                        end
                    end
                end
                default: m_phase = M_IDLE;
            endcase
        end

        // Compare the DUT against the model
        if (m_on) begin
            chk("cmd_ready", cmd_ready, m_phase == M_IDLE);
            chk("busy", busy, m_phase != M_IDLE);
            chk("rsp_valid", rsp_valid, m_phase == M_RESP);
            chk("wb_cyc_o", wb_cyc_o, m_phase == M_BURST);
            chk("wb_stb_o", wb_stb_o, m_phase == M_BURST);
            if (m_phase == M_BURST) begin
                ea = m_base + 32'(4 * m_beats);
                chk("wb_addr_o", wb_addr_o, ea);
                chk("wb_we_o", wb_we_o, m_we);
                chk("wb_sel_o", wb_sel_o, 4'hF);
                chk("wb_bte_o", wb_bte_o, 2'b00);
                chk("wb_dat_o", wb_dat_o, m_we ? (ea ^ m_seed) : 32'h0);
                chk("wb_cti_o", wb_cti_o,
                    (m_len == 0) ? 3'b000 : ((m_beats == m_len) ? 3'b111 : 3'b010));
            end
            chk("rsp_err_cnt", rsp_err_cnt, m_err);
            chk("rsp_first_err_addr", rsp_first_err_addr, m_first);
            chk("rsp_timeout", rsp_timeout, m_to);
            chk("rsp_bus_err", rsp_bus_err, m_be);
            if (wb_stb_o === 1'b1) stb_cycles++;
        end

        // Slave response for the coming edge
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
        if (m_on && wb_stb_o === 1'b1) begin
            if (new_beat) begin
                wait_left = rand_waits ? int'($urandom_range(5, 0)) : fixed_wait;
                new_beat = 1'b0;
            end
            if (!never_ack) begin
                if (wait_left > 0) wait_left--;
                else if (err_beat == m_beats) wb_err_i = 1'b1;
                else begin
                    wb_ack_i = 1'b1; new_beat = 1'b1;
                    if (!wb_we_o) begin
                        if (use_bad && wb_addr_o == bad_addr) wb_dat_i = '0;
                        else if (mem.exists(wb_addr_o)) wb_dat_i = mem[wb_addr_o];
                        else wb_dat_i = 32'hDEADBEEF;
                    end
                end
            end
        end
        p_stb = wb_stb_o; p_ack = wb_ack_i; p_err = wb_err_i;
        p_dat_i = wb_dat_i; p_dat_o = wb_dat_o; p_cti = wb_cti_o;
    end

    // ---------------- stimulus ----------------
    task automatic set_slave(input bit rw, input int fw, input bit na, input int eb,
                             input bit ub, input logic [31:0] ba);
        rand_waits = rw; fixed_wait = fw; never_ack = na; err_beat = eb;
        use_bad = ub; bad_addr = ba; new_beat = 1'b1; wait_left = 0;
    endtask

    // Returns k: the cycle index (accept cycle = 0) in which rsp_valid is seen
    task automatic run_cmd(input bit we, input logic [31:0] a, input int len,
                           input logic [31:0] seed, output int k);
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = BL'(len); cmd_seed = seed;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        k = 1;
        while (rsp_valid !== 1'b1 && k < 400) begin
            @(negedge sys_clk);
            k++;
        end
        if (rsp_valid !== 1'b1) chk("rsp_wait", rsp_valid, 1'b1);
        #1;
    endtask

    initial begin
        int k;
        int rv_seen;
        RESETN = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cyc", wb_cyc_o, 1'b0);
        chk("rst_stb", wb_stb_o, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_err_cnt", rsp_err_cnt, 0);
        chk("rst_first", rsp_first_err_addr, 0);
        chk("rst_addr", wb_addr_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_cti", wb_cti_o, 0);
        RESETN = 1'b1;

        // Four-beat write, zero-wait
        set_slave(0, 0, 0, -1, 0, '0);
        run_cmd(1'b1, 32'h100, 3, 32'hA5A5A5A5, k);
        chk("t1_span_incl", k + 1, 6);
        chk("t1_beats", log_n, 4);
        chk("t1_d0", log_dat[0], 32'hA5A5A4A5);
        chk("t1_d1", log_dat[1], 32'hA5A5A4A1);
        chk("t1_d2", log_dat[2], 32'hA5A5A4AD);
        chk("t1_d3", log_dat[3], 32'hA5A5A4A9);
        chk("t1_cti0", log_cti[0], 3'b010);
        chk("t1_cti1", log_cti[1], 3'b010);
        chk("t1_cti2", log_cti[2], 3'b010);
        chk("t1_cti3", log_cti[3], 3'b111);
        chk("t1_err", rsp_err_cnt, 0);

        // Read-back with random wait states
        set_slave(1, 0, 0, -1, 0, '0);
        run_cmd(1'b0, 32'h100, 3, 32'hA5A5A5A5, k);
        chk("t2_beats", log_n, 4);
        chk("t2_err", rsp_err_cnt, 0);
        chk("t2_to", rsp_timeout, 1'b0);
        chk("t2_be", rsp_bus_err, 1'b0);

        // Read with the beat at 0x108 corrupted
        set_slave(0, 0, 0, -1, 1, 32'h108);
        run_cmd(1'b0, 32'h100, 3, 32'hA5A5A5A5, k);
        chk("t3_beats", log_n, 4);
        chk("t3_err", rsp_err_cnt, 1);
        chk("t3_first", rsp_first_err_addr, 32'h108);

        // Single write with a two-wait ack
        set_slave(0, 2, 0, -1, 0, '0);
        run_cmd(1'b1, 32'h3FFFFFFC, 0, 32'h12345678, k);
        chk("t4_k", k, 4);
        chk("t4_beats", log_n, 1);
        chk("t4_cti", log_cti[0], 3'b000);
        chk("t4_d0", log_dat[0], 32'h2DCBA984);

        // Unaligned start near the top of the address space wraps to 0
        set_slave(0, 0, 0, -1, 0, '0);
        run_cmd(1'b1, 32'hFFFFFFFA, 3, 32'h0, k);
        chk("t4b_d0", log_dat[0], 32'hFFFFFFF8);
        chk("t4b_d2", log_dat[2], 32'h00000000);
        chk("t4b_d3", log_dat[3], 32'h00000004);

        // Slave never answers
        set_slave(0, 0, 1, -1, 0, '0);
        run_cmd(1'b1, 32'h200, 3, 32'h0, k);
        chk("t5_to", rsp_timeout, 1'b1);
        chk("t5_stb_cycles", stb_cycles, 16);
        chk("t5_beats", log_n, 0);
        chk("t5_be", rsp_bus_err, 1'b0);

        // Error on beat 2 of 8
        set_slave(0, 0, 0, 1, 0, '0);
        run_cmd(1'b1, 32'h300, 7, 32'h0, k);
        chk("t6_be", rsp_bus_err, 1'b1);
        chk("t6_to", rsp_timeout, 1'b0);
        chk("t6_beats", log_n, 1);
        chk("t6_stb_cycles", stb_cycles, 2);

        // Reset during beat 3 of 8
        set_slave(0, 0, 0, -1, 0, '0);
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h400; cmd_len = BL'(7); cmd_seed = 32'h0;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge sys_clk);
        RESETN = 1'b0;
        @(negedge sys_clk);
        chk("t7_cyc", wb_cyc_o, 1'b0);
        chk("t7_stb", wb_stb_o, 1'b0);
        RESETN = 1'b1;
        rv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid === 1'b1) rv_seen++;
            @(negedge sys_clk);
        end
        chk("t7_no_rsp", rv_seen, 0);
        chk("t7_ready", cmd_ready, 1'b1);

        // Normal command after the reset
        set_slave(1, 0, 0, -1, 0, '0);
        run_cmd(1'b0, 32'h100, 3, 32'hA5A5A5A5, k);
        chk("t8_beats", log_n, 4);
        chk("t8_err", rsp_err_cnt, 0);

        repeat (2) @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
